// File: rtl/updown_counter_param.sv
// updown_counter_param: cascadable up/down counter with runtime modulus and saturate/wrap mode
//
// Ports:
//   i_clk      sole clock, all state updates on the rising edge
//   i_mr       synchronous reset, active-low (clears Q and OVF)
//   i_load     synchronous parallel load, active-low (loads min(D, MAX))
//   i_en       count enable, active-high
//   i_ci       cascade carry-in, active-high (tie high when standalone)
//   i_updown   direction, 0 = up, 1 = down
//   i_max      runtime modulus limit, count range is 0..MAX
//   i_d        parallel load data
//   i_clr_ovf  synchronous clear of OVF, active-high (loses to a set)
//   o_q        registered count value
//   o_tc       combinational terminal-count indicator
//   o_co       combinational cascade carry-out
//   o_ovf      registered sticky terminal-event flag
module updown_counter_param #(
    parameter int WIDTH = 4,
    parameter int SAT   = 0
) (
    input  logic             i_clk,
    input  logic             i_mr,
    input  logic             i_load,
    input  logic             i_en,
    input  logic             i_ci,
    input  logic             i_updown,
    input  logic [WIDTH-1:0] i_max,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_clr_ovf,
    output logic [WIDTH-1:0] o_q,
    output logic             o_tc,
    output logic             o_co,
    output logic             o_ovf
);
    localparam bit SAT_EN = (SAT != 0);

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic             w_cnt;
    logic             w_tc;
    logic [WIDTH-1:0] w_ld;
    logic [WIDTH-1:0] w_up;
    logic [WIDTH-1:0] w_dn;

    // LOAD is active-low, so a pending load masks counting in the same cycle
    assign w_cnt = i_en & i_ci & i_load;
    assign w_tc  = i_updown ? (r_q == '0) : (r_q >= i_max);
    assign w_ld  = (i_d <= i_max) ? i_d : i_max;

    always_comb begin
        w_up = (r_q < i_max) ? r_q + 1'b1 : (SAT_EN ? i_max : '0);
        // A Q stranded above a lowered MAX snaps down to MAX first
        w_dn = (r_q > i_max) ? i_max : (r_q != '0) ? r_q - 1'b1 : (SAT_EN ? '0 : i_max);
    end

    always_ff @(posedge i_clk) begin
        if (!i_mr) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (!i_load)
                r_q <= w_ld;
            else if (w_cnt)
                r_q <= i_updown ? w_dn : w_up;
            // Set wins over clear when both occur on the same edge
            if (w_cnt && w_tc)
                r_ovf <= 1'b1;
            else if (i_clr_ovf)
                r_ovf <= 1'b0;
        end
    end

    assign o_q   = r_q;
    assign o_tc  = w_tc;
    assign o_co  = w_tc & w_cnt;
    assign o_ovf = r_ovf;
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: directed bench with a behavioural reference for wrap, saturate and cascaded counters
module tb_updown_counter_param;
    logic       clk = 1'b0;
    logic       mr, load, en, ci, ud, clr;
    logic [3:0] mx, d;
    logic [3:0] q_w, q_s, cq0, cq1;
    logic       tc_w, co_w, ovf_w, tc_s, co_s, ovf_s;
    logic       ctc0, cco0, covf0, ctc1, cco1, covf1;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         started = 1'b0;
    int         mq [2];
    int         mo [2];
    int         dec = 0;
    int         mco0 = 0;
    int         mco1 = 0;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .SAT(0)) dut_w (
        .i_clk(clk), .i_mr(mr), .i_load(load), .i_en(en), .i_ci(ci), .i_updown(ud),
        .i_max(mx), .i_d(d), .i_clr_ovf(clr), .o_q(q_w), .o_tc(tc_w), .o_co(co_w), .o_ovf(ovf_w));

    updown_counter_param #(.WIDTH(4), .SAT(1)) dut_s (
        .i_clk(clk), .i_mr(mr), .i_load(load), .i_en(en), .i_ci(ci), .i_updown(ud),
        .i_max(mx), .i_d(d), .i_clr_ovf(clr), .o_q(q_s), .o_tc(tc_s), .o_co(co_s), .o_ovf(ovf_s));

    updown_counter_param #(.WIDTH(4), .SAT(0)) cas0 (
        .i_clk(clk), .i_mr(mr), .i_load(1'b1), .i_en(1'b1), .i_ci(1'b1), .i_updown(1'b0),
        .i_max(4'd9), .i_d(4'd0), .i_clr_ovf(1'b0), .o_q(cq0), .o_tc(ctc0), .o_co(cco0), .o_ovf(covf0));

    updown_counter_param #(.WIDTH(4), .SAT(0)) cas1 (
        .i_clk(clk), .i_mr(mr), .i_load(1'b1), .i_en(1'b1), .i_ci(cco0), .i_updown(1'b0),
        .i_max(4'd9), .i_d(4'd0), .i_clr_ovf(1'b0), .o_q(cq1), .o_tc(ctc1), .o_co(cco1), .o_ovf(covf1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic bit term(input int q, input int m, input bit down);
        return down ? (q == 0) : (q >= m);
    endfunction

    // Next count straight from the rule list: up climbs to the limit, down falls to zero
    function automatic int next_q(input int q, input int m, input bit down, input bit sat);
        if (!down) return (q < m) ? q + 1 : (sat ? m : 0);
        if (q > m) return m;
        if (q > 0) return q - 1;
        return sat ? 0 : m;
    endfunction

    // Reference model: standalone pair plus the cascade viewed as one decimal count 00..99
    always @(posedge clk) begin
        started <= 1'b1;
        for (int s = 0; s < 2; s++) begin
            if (!mr) begin
                mq[s] = 0;
                mo[s] = 0;
            end else if (!load) begin
                mq[s] = (d <= mx) ? int'(d) : int'(mx);
                if (clr) mo[s] = 0;
            end else if (en && ci) begin
                if (term(mq[s], int'(mx), ud)) mo[s] = 1;
                else if (clr) mo[s] = 0;
                mq[s] = next_q(mq[s], int'(mx), ud, s == 1);
            end else if (clr) begin
                mo[s] = 0;
            end
        end
        if (!mr) begin
            dec = 0; mco0 = 0; mco1 = 0;
        end else begin
            if (dec % 10 == 9) mco0 = 1;
            if (dec == 99) mco1 = 1;
            dec = (dec + 1) % 100;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("q_wrap", q_w, mq[0]);
            chk("tc_wrap", tc_w, term(mq[0], int'(mx), ud));
            chk("co_wrap", co_w, term(mq[0], int'(mx), ud) & en & ci & load);
            chk("ovf_wrap", ovf_w, mo[0]);
            chk("q_sat", q_s, mq[1]);
            chk("tc_sat", tc_s, term(mq[1], int'(mx), ud));
            chk("co_sat", co_s, term(mq[1], int'(mx), ud) & en & ci & load);
            chk("ovf_sat", ovf_s, mo[1]);
            chk("cas_lo", cq0, dec % 10);
            chk("cas_hi", cq1, dec / 10);
            chk("cas_co0", cco0, dec % 10 == 9);
            chk("cas_co1", cco1, dec == 99);
            chk("cas_ovf0", covf0, mco0);
            chk("cas_ovf1", covf1, mco1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit hit;
        mr = 0; load = 1; en = 1; ci = 1; ud = 0; mx = 4'd9; d = 4'd0; clr = 0;
        tick(2);
        chk("lit_rst_q", q_w, 0);
        chk("lit_rst_ovf", ovf_w, 0);
        chk("lit_rst_tc", tc_w, 0);
        mr = 1;
        tick(9);
        chk("lit_up_q9", q_w, 9);
        chk("lit_up_tc9", tc_w, 1);
        chk("lit_up_co9", co_w, 1);
        chk("lit_up_ovf_pre", ovf_w, 0);
        tick(1);
        chk("lit_wrap_q0", q_w, 0);
        chk("lit_wrap_ovf", ovf_w, 1);
        chk("lit_sat_hold9", q_s, 9);
        chk("lit_sat_ovf", ovf_s, 1);
        load = 0; d = 4'd12;
        tick(1);
        chk("lit_load_clip", q_w, 9);
        d = 4'd5;
        tick(1);
        chk("lit_load_5", q_w, 5);
        d = 4'd2; clr = 1;
        tick(1);
        chk("lit_load_2", q_s, 2);
        chk("lit_clr_ovf", ovf_s, 0);
        load = 1; clr = 0; ud = 1;
        tick(1);
        chk("lit_dn_1", q_s, 1);
        tick(1);
        chk("lit_dn_0", q_s, 0);
        chk("lit_dn_ovf_pre", ovf_s, 0);
        tick(1);
        chk("lit_dn_hold0", q_s, 0);
        chk("lit_dn_ovf_set", ovf_s, 1);
        chk("lit_wrap_dn9", q_w, 9);
        tick(1);
        chk("lit_dn_hold0b", q_s, 0);
        clr = 1;
        tick(1);
        chk("lit_set_beats_clr", ovf_s, 1);
        en = 0;
        tick(1);
        chk("lit_clr_alone", ovf_s, 0);
        en = 1; clr = 0; ud = 0; load = 0; d = 4'd8;
        tick(1);
        load = 1; mx = 4'd5;
        #1;
        chk("lit_max_tc_now", tc_s, 1);
        tick(1);
        chk("lit_above_max_wrap", q_w, 0);
        chk("lit_above_max_sat", q_s, 5);
        ud = 1; mx = 4'd9; load = 0; d = 4'd8;
        tick(1);
        load = 1; mx = 4'd5;
        tick(1);
        chk("lit_dn_snap_max", q_w, 5);
        mx = 4'd0; ud = 0;
        tick(2);
        chk("lit_max0_q", q_w, 0);
        chk("lit_max0_tc", tc_w, 1);
        chk("lit_max0_co", co_w, 1);
        ud = 1;
        tick(1);
        chk("lit_max0_dn", q_w, 0);
        en = 0;
        #1;
        chk("lit_max0_co_off", co_w, 0);
        mx = 4'd9; ud = 0; en = 1; load = 0; d = 4'd6;
        tick(1);
        load = 1;
        tick(1);
        chk("lit_cnt_7", q_w, 7);
        mr = 0; load = 0; d = 4'd3;
        tick(1);
        chk("lit_mr_q", q_w, 0);
        chk("lit_mr_ovf", ovf_w, 0);
        mr = 1; load = 1;
        tick(1);
        chk("lit_resume_1", q_w, 1);
        tick(1);
        chk("lit_resume_2", q_w, 2);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (cq0 == 4'd9 && cq1 == 4'd9) hit = 1;
            else tick(1);
        end
        chk("lit_cas_reach99", hit, 1);
        tick(1);
        chk("lit_cas_lo0", cq0, 0);
        chk("lit_cas_hi0", cq1, 0);
        chk("lit_cas_ovf1", covf1, 1);
        tick(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
